// File: rtl/lc3_control_fsm.sv
// LC3 pipeline controller: start-up ramp, memory-op stalls and control-flow
// bubbles, plus the combinational operand bypass selects for decode.
module lc3_control_fsm #(
    parameter int CF_BUBBLES = 3
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        complete_instr_i,
    input  logic        complete_data_i,
    input  logic [15:0] ir_i,
    input  logic [15:0] ir_exec_i,
    input  logic [15:0] imem_dout_i,
    input  logic [2:0]  psr_i,
    input  logic [2:0]  nzp_i,
    output logic        enable_updatepc_o,
    output logic        enable_fetch_o,
    output logic        enable_decode_o,
    output logic        enable_execute_o,
    output logic        enable_writeback_o,
    output logic        br_taken_o,
    output logic        bypass_alu_1_o,
    output logic        bypass_alu_2_o,
    output logic        bypass_mem_1_o,
    output logic        bypass_mem_2_o,
    output logic [1:0]  mem_state_o
);
    // state     | meaning
    // S_RUN     | pipeline advancing (start-up ramp in progress or complete)
    // S_MEM     | stage enables held low while the data-memory sequence runs
    // S_CF_WAIT | fetch held low for CF_BUBBLES cycles after a BR/JMP fetch
    typedef enum logic [1:0] {S_RUN, S_MEM, S_CF_WAIT} state_t;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;
    localparam int CNT_W = (CF_BUBBLES > 1) ? $clog2(CF_BUBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CF_BUBBLES - 1);

    function automatic logic is_alu(input logic [3:0] op);
        return op inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
    endfunction
    function automatic logic is_load(input logic [3:0] op);
        return op inside {4'b0010, 4'b0110, 4'b1010};
    endfunction
    function automatic logic is_store(input logic [3:0] op);
        return op inside {4'b0011, 4'b0111, 4'b1011};
    endfunction

    state_t           state_q;
    logic [2:0]       vld_q;
    logic [CNT_W-1:0] cf_cnt_q;
    logic             cf_pend_q, cf_jmp_q, sti_q;
    logic             upc_q, fetch_q, decode_q, execute_q, writeback_q, br_q;
    logic [1:0]       mem_state_q;

    logic [3:0] op_exec, op_fetch;
    logic       exec_alu, exec_two_src, exec_load, mem_go, cf_seen, cf_go, br_cond;
    logic       src1_hit, src2_hit;
    logic       sig_unused;

    assign op_exec      = ir_exec_i[15:12];
    assign op_fetch     = imem_dout_i[15:12];
    assign exec_alu     = is_alu(op_exec);
    assign exec_two_src = (op_exec == 4'b0001) || (op_exec == 4'b0101);
    assign exec_load    = is_load(op_exec);
    assign mem_go       = execute_q && (exec_load || is_store(op_exec));
    assign cf_seen      = complete_instr_i && (op_fetch == 4'b0000 || op_fetch == 4'b1100);
    assign cf_go        = cf_seen || cf_pend_q;
    assign br_cond      = |(ir_exec_i[11:9] & psr_i);
    assign sig_unused   = ^{nzp_i, ir_i[15:9], ir_i[4:3], ir_exec_i[8:0], imem_dout_i[11:0]};

    // A load's destination can only collide with an ALU one if the opcodes overlap, which they do not.
    assign src1_hit       = !reset_i && (ir_exec_i[11:9] == ir_i[8:6]);
    assign src2_hit       = !reset_i && !ir_i[5] && (ir_exec_i[11:9] == ir_i[2:0]);
    assign bypass_alu_1_o = src1_hit && exec_alu;
    assign bypass_alu_2_o = src2_hit && exec_two_src;
    assign bypass_mem_1_o = src1_hit && exec_load;
    assign bypass_mem_2_o = src2_hit && exec_load;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_RUN;
            vld_q       <= '0;
            cf_cnt_q    <= '0;
            cf_pend_q   <= 1'b0;
            cf_jmp_q    <= 1'b0;
            sti_q       <= 1'b0;
            upc_q       <= 1'b0;
            fetch_q     <= 1'b0;
            decode_q    <= 1'b0;
            execute_q   <= 1'b0;
            writeback_q <= 1'b0;
            br_q        <= 1'b0;
            mem_state_q <= MS_IDLE;
        end else begin
            br_q        <= 1'b0;
            writeback_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (complete_instr_i) vld_q <= {vld_q[1:0], 1'b1};
                    if (cf_seen) cf_jmp_q <= (op_fetch == 4'b1100);
                    if (mem_go) begin
                        state_q   <= S_MEM;
                        upc_q     <= 1'b0;
                        fetch_q   <= 1'b0;
                        decode_q  <= 1'b0;
                        execute_q <= 1'b0;
                        cf_pend_q <= cf_go;
                        sti_q     <= (op_exec == 4'b1011);
                        case (op_exec)
                            4'b0010, 4'b0110: mem_state_q <= MS_READ;
                            4'b1010, 4'b1011: mem_state_q <= MS_IND;
                            default:          mem_state_q <= MS_WRITE;
                        endcase
                    end else begin
                        upc_q       <= complete_instr_i && !cf_go;
                        fetch_q     <= complete_instr_i && !cf_go;
                        decode_q    <= complete_instr_i && vld_q[0];
                        execute_q   <= complete_instr_i && vld_q[1];
                        writeback_q <= complete_instr_i && vld_q[2] && exec_alu;
                        if (cf_go) begin
                            state_q   <= S_CF_WAIT;
                            cf_cnt_q  <= '0;
                            cf_pend_q <= 1'b0;
                        end
                    end
                end
                S_MEM: begin
                    upc_q     <= 1'b0;
                    fetch_q   <= 1'b0;
                    decode_q  <= 1'b0;
                    execute_q <= 1'b0;
                    if (complete_data_i) begin
                        case (mem_state_q)
                            MS_IND: mem_state_q <= sti_q ? MS_WRITE : MS_READ;
                            MS_READ: begin
                                mem_state_q <= MS_IDLE;
                                writeback_q <= 1'b1;
                                state_q     <= S_RUN;
                            end
                            default: begin
                                mem_state_q <= MS_IDLE;
                                state_q     <= S_RUN;
                            end
                        endcase
                    end
                end
                S_CF_WAIT: begin
                    fetch_q     <= 1'b0;
                    decode_q    <= vld_q[0];
                    execute_q   <= vld_q[1];
                    writeback_q <= vld_q[2] && exec_alu;
                    if (cf_cnt_q == CNT_LAST) begin
                        upc_q    <= 1'b1;
                        br_q     <= cf_jmp_q || br_cond;
                        state_q  <= S_RUN;
                        cf_cnt_q <= '0;
                    end else begin
                        upc_q    <= 1'b0;
                        cf_cnt_q <= cf_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign enable_updatepc_o  = upc_q;
    assign enable_fetch_o     = fetch_q;
    assign enable_decode_o    = decode_q;
    assign enable_execute_o   = execute_q;
    assign enable_writeback_o = writeback_q;
    assign br_taken_o         = br_q;
    assign mem_state_o        = mem_state_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: a behavioural model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_lc3_control_fsm;
    localparam int CF_BUBBLES = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        complete_instr = 1'b0;
    logic        complete_data = 1'b0;
    logic [15:0] ir = '0, ir_exec = '0, imem_dout = '0;
    logic [2:0]  psr = '0, nzp = '0;
    logic        en_upc, en_fetch, en_dec, en_exe, en_wb, br_taken;
    logic        bp_a1, bp_a2, bp_m1, bp_m2;
    logic [1:0]  mem_state;

    always #5 clock = ~clock;

    lc3_control_fsm #(.CF_BUBBLES(CF_BUBBLES)) dut (
        .clock_i(clock), .reset_i(reset),
        .complete_instr_i(complete_instr), .complete_data_i(complete_data),
        .ir_i(ir), .ir_exec_i(ir_exec), .imem_dout_i(imem_dout),
        .psr_i(psr), .nzp_i(nzp),
        .enable_updatepc_o(en_upc), .enable_fetch_o(en_fetch),
        .enable_decode_o(en_dec), .enable_execute_o(en_exe),
        .enable_writeback_o(en_wb), .br_taken_o(br_taken),
        .bypass_alu_1_o(bp_a1), .bypass_alu_2_o(bp_a2),
        .bypass_mem_1_o(bp_m1), .bypass_mem_2_o(bp_m2),
        .mem_state_o(mem_state)
    );

    typedef struct packed {
        logic [7:0] regs;   // upc fetch dec exe wb br ms[1:0]
        logic [3:0] byp;    // alu1 alu2 mem1 mem2
    } exp_t;

    exp_t sb_q[$];
    bit   sb_armed = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model: pipeline fill level, pending memory phases, bubbles left
    int   ramp = 0;
    int   mem_q[$];
    int   cf_left = 0;
    bit   pend = 0, cf_jmp = 0;
    logic m_upc = 0, m_fetch = 0, m_dec = 0, m_exe = 0, m_wb = 0, m_br = 0;
    logic [1:0] m_ms = 2'd3;

    function automatic bit op_alu(input logic [15:0] i);
        return i[15:12] == 4'h1 || i[15:12] == 4'h5 || i[15:12] == 4'h9 || i[15:12] == 4'hE;
    endfunction
    function automatic bit op_load(input logic [15:0] i);
        return i[15:12] == 4'h2 || i[15:12] == 4'h6 || i[15:12] == 4'hA;
    endfunction
    function automatic bit op_store(input logic [15:0] i);
        return i[15:12] == 4'h3 || i[15:12] == 4'h7 || i[15:12] == 4'hB;
    endfunction
    function automatic bit op_cf(input logic [15:0] i);
        return i[15:12] == 4'h0 || i[15:12] == 4'hC;
    endfunction

    function automatic logic [3:0] exp_bypass(input logic r, input logic [15:0] d, input logic [15:0] x);
        bit s1, s2, two;
        s1  = (x[11:9] == d[8:6]);
        s2  = !d[5] && (x[11:9] == d[2:0]);
        two = (x[15:12] == 4'h1) || (x[15:12] == 4'h5);
        if (r) return 4'b0000;
        return {op_alu(x) && s1, two && s2, op_load(x) && s1, op_load(x) && s2};
    endfunction

    task automatic model_edge();
        bit go_cf, was_exe;
        int last;
        if (reset) begin
            {m_upc, m_fetch, m_dec, m_exe, m_wb, m_br} = '0;
            m_ms = 2'd3; ramp = 0; mem_q.delete(); cf_left = 0; pend = 0; cf_jmp = 0;
            return;
        end
        m_br = 0;
        m_wb = 0;
        if (mem_q.size() != 0) begin
            {m_upc, m_fetch, m_dec, m_exe} = '0;
            if (complete_data) begin
                last = mem_q.pop_front();
                if (mem_q.size() == 0) begin
                    m_ms = 2'd3;
                    m_wb = (last == 0);
                end else begin
                    m_ms = 2'(mem_q[0]);
                end
            end
        end else if (cf_left != 0) begin
            m_fetch = 0;
            m_dec = (ramp >= 1);
            m_exe = (ramp >= 2);
            m_wb  = (ramp >= 3) && op_alu(ir_exec);
            cf_left--;
            m_upc = (cf_left == 0);
            if (cf_left == 0) m_br = cf_jmp || ((ir_exec[11:9] & psr) != 3'b000);
        end else begin
            was_exe = m_exe;
            go_cf = (complete_instr && op_cf(imem_dout)) || pend;
            if (complete_instr && op_cf(imem_dout)) cf_jmp = (imem_dout[15:12] == 4'hC);
            if (was_exe && (op_load(ir_exec) || op_store(ir_exec))) begin
                {m_upc, m_fetch, m_dec, m_exe} = '0;
                pend = go_cf;
                mem_q.delete();
                case (ir_exec[15:12])
                    4'h2, 4'h6: mem_q.push_back(0);
                    4'hA: begin mem_q.push_back(1); mem_q.push_back(0); end
                    4'hB: begin mem_q.push_back(1); mem_q.push_back(2); end
                    default: mem_q.push_back(2);
                endcase
                m_ms = 2'(mem_q[0]);
            end else begin
                m_upc   = complete_instr && !go_cf;
                m_fetch = complete_instr && !go_cf;
                m_dec   = complete_instr && (ramp >= 1);
                m_exe   = complete_instr && (ramp >= 2);
                m_wb    = complete_instr && (ramp >= 3) && op_alu(ir_exec);
                if (go_cf) begin
                    cf_left = CF_BUBBLES;
                    pend = 0;
                end
            end
            if (complete_instr && ramp < 3) ramp++;
        end
    endtask

    // One clock: model the edge with the inputs it sampled, then apply new inputs.
    task automatic step(input logic r, input logic ci, input logic cd,
                        input logic [15:0] d, input logic [15:0] x,
                        input logic [15:0] f, input logic [2:0] p);
        exp_t e;
        @(posedge clock);
        #1;
        model_edge();
        reset = r; complete_instr = ci; complete_data = cd;
        ir = d; ir_exec = x; imem_dout = f; psr = p;
        nzp = 3'($urandom_range(0, 7));
        e.regs = {m_upc, m_fetch, m_dec, m_exe, m_wb, m_br, m_ms};
        e.byp  = exp_bypass(r, d, x);
        sb_q.push_back(e);
        sb_armed = 1;
    endtask

    function automatic logic [15:0] rand_instr();
        return 16'($urandom_range(0, 65535));
    endfunction

    initial begin : monitor
        exp_t e;
        logic [7:0] got_regs;
        logic [3:0] got_byp;
        forever begin
            @(negedge clock);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                got_regs = {en_upc, en_fetch, en_dec, en_exe, en_wb, br_taken, mem_state};
                got_byp  = {bp_a1, bp_a2, bp_m1, bp_m2};
                checks++;
                if (got_regs !== e.regs) begin
                    errors++;
                    $display("FAIL enables t=%0t got=%b want=%b (upc,fetch,dec,exe,wb,br,ms)", $time, got_regs, e.regs);
                end
                checks++;
                if (got_byp !== e.byp) begin
                    errors++;
                    $display("FAIL bypass t=%0t got=%b want=%b (a1,a2,m1,m2)", $time, got_byp, e.byp);
                end
            end else if (sb_armed) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty t=%0t got=0 entries want>=1", $time);
            end
        end
    end

    initial begin : stimulus
        // reset, then an ADD stream: ramp-up with bypass hits on both sources
        repeat (2) step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000);
        repeat (6) step(0, 1, 0, 16'h1441, 16'h1240, 16'h1000, 3'b001);
        // LDI in execute: indirect read then read, writeback on the final step
        for (int i = 0; i < 7; i++)
            step(0, 1, (i == 2 || i == 5), 16'h1441, 16'hA200, 16'h1000, 3'b001);
        repeat (4) step(0, 1, 0, 16'h1461, 16'h1042, 16'h1000, 3'b001);
        // BRz fetched, condition true then false, then JMP
        step(0, 1, 0, 16'h1441, 16'h0405, 16'h0405, 3'b010);
        repeat (6) step(0, 1, 0, 16'h1441, 16'h0405, 16'h1000, 3'b010);
        step(0, 1, 0, 16'h1441, 16'h0405, 16'h0405, 3'b001);
        repeat (6) step(0, 1, 0, 16'h1441, 16'h0405, 16'h1000, 3'b001);
        step(0, 1, 0, 16'h1441, 16'h0405, 16'hC1C0, 3'b001);
        repeat (6) step(0, 1, 0, 16'h1441, 16'h1240, 16'h1000, 3'b001);
        // complete_instr low for two cycles
        repeat (2) step(0, 0, 0, 16'h1441, 16'h1240, 16'h1000, 3'b001);
        repeat (3) step(0, 1, 0, 16'h1441, 16'h1240, 16'h1000, 3'b001);
        // LDR (mem bypass) enters MEM, reset abandons it, ramp restarts
        step(0, 1, 0, 16'h1441, 16'h6240, 16'h1000, 3'b001);
        step(1, 1, 0, 16'h1441, 16'h6240, 16'h1000, 3'b001);
        repeat (6) step(0, 1, 0, 16'h1441, 16'h1240, 16'h1000, 3'b001);
        // LD and BR in the same cycle: the branch waits for MEM to finish
        step(0, 1, 0, 16'h1441, 16'h2200, 16'h0E00, 3'b100);
        step(0, 1, 1, 16'h1441, 16'h2200, 16'h1000, 3'b100);
        repeat (8) step(0, 1, 0, 16'h1441, 16'h1240, 16'h1000, 3'b100);
        // randomized traffic
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0), rand_instr(), rand_instr(),
                 rand_instr(), 3'($urandom_range(0, 7)));
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
